// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

    typedef logic [3:0] key_code_t;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;

    // Index of the lowest active-low row; caller guarantees at least one row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Free-running column dwell counter; tick marks the last cycle of each dwell period.
module scan_timer #(
    parameter int unsigned SCAN_N = 18
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [SCAN_N-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + SCAN_N'(1);
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and one-cycle key strobe.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_N       = 18,
    parameter int unsigned DB_TICKS     = 4,
    parameter int unsigned REPEAT_TICKS = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output key_code_t key_code,
    output logic      key_valid,
    output logic      key_held
);

    localparam int unsigned CNT_W = $clog2(DB_TICKS + 1);

    logic        tick;
    logic [3:0]  sync1_q, rs_q;
    kp_state_t   state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    key_code_t   code_q, code_d;
    logic [3:0]  col_q;
    logic        valid_q, strobe;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0] rep_q, rep_d;
`else
    logic unused_repeat_ticks;
    assign unused_repeat_ticks = ^REPEAT_TICKS;
`endif

    scan_timer #(
        .SCAN_N (SCAN_N)
    ) u_scan_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and datapath registers; rows idle high through the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 4'hF;
            rs_q      <= 4'hF;
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            code_q    <= '0;
            col_q     <= 4'b1110;
            valid_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            sync1_q   <= row;
            rs_q      <= sync1_q;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            col_q     <= ~(4'b0001 << col_idx_d);
            valid_q   <= strobe;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        strobe    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (rs_q != 4'hF) begin
                        row_idx_d = lowest_low(rs_q);
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!rs_q[row_idx_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DB_TICKS)) begin
                            code_d  = {row_idx_q, col_idx_q};
                            strobe  = 1'b1;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HELD: begin
                    if (rs_q == 4'hF) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rep_d = rep_q + REP_W'(1);
                        if (rep_d == REP_W'(REPEAT_TICKS)) begin
                            strobe = 1'b1;
                            rep_d  = '0;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (rs_q == 4'hF) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DB_TICKS)) begin
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        // Bounce during release: back to HELD, repeat count preserved.
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        col       = col_q;
        key_code  = code_q;
        key_valid = valid_q;
        key_held  = (state_q == HELD) || (state_q == RELEASE);
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan (SCAN_N=4, DB_TICKS=3, REPEAT_TICKS=4).
module tb_keypad_scan;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;       // bit r*4+c pressed
    int          checks;
    int          failures;
    int          vcount;
    logic [3:0]  last_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD_PULSES = 6;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    keypad_scan #(
        .SCAN_N       (4),
        .DB_TICKS     (3),
        .REPEAT_TICKS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    initial begin
        vcount    = 0;
        last_code = 4'h0;
    end
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            vcount    = vcount + 1;
            last_code = key_code;
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After this the next posedge is edge 1 with the dwell counter at 0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        keys  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols [5];
        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        @(negedge clk);
        reset = 1'b1;
        keys  = '0;
        #1;
        checks++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got col=%b v=%b h=%b code=%h exp col=1110 v=0 h=0 code=0",
                     col, key_valid, key_held, key_code);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        edges(8);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (col !== exp_cols[i]) begin
                failures++;
                $display("FAIL idle_col[%0d] got=%b exp=%b", i, col, exp_cols[i]);
            end
            checks++;
            if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
                failures++;
                $display("FAIL idle_outputs[%0d] got v=%b h=%b code=%h exp v=0 h=0 code=0",
                         i, key_valid, key_held, key_code);
            end
            edges(16);
        end
    endtask

    task automatic test_press();
        int start;
        do_reset();
        keys[9] = 1'b1;  // row 2, column 1
        start = vcount;
        edges(63);
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL press_early got v=%b h=%b exp v=0 h=0", key_valid, key_held);
        end
        edges(1);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin
            failures++;
            $display("FAIL press_accept got v=%b code=%h h=%b exp v=1 code=9 h=1",
                     key_valid, key_code, key_held);
        end
        edges(1);
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_strobe_width got v=%b exp v=0", key_valid);
        end
        edges(35);
        checks++;
        if (vcount - start !== 1 || col !== 4'b1101 || key_held !== 1'b1) begin
            failures++;
            $display("FAIL press_hold got pulses=%0d col=%b h=%b exp pulses=1 col=1101 h=1",
                     vcount - start, col, key_held);
        end
    endtask

    task automatic test_bounce();
        int start;
        do_reset();
        start = vcount;
        edges(20);
        keys[9] = 1'b1;
        edges(18);
        keys = '0;
        edges(18);
        checks++;
        if (col !== 4'b1011 || key_held !== 1'b0 || vcount - start !== 0) begin
            failures++;
            $display("FAIL bounce got col=%b h=%b pulses=%0d exp col=1011 h=0 pulses=0",
                     col, key_held, vcount - start);
        end
    endtask

    task automatic test_release();
        int start;
        do_reset();
        start = vcount;
        keys[9] = 1'b1;
        edges(100);
        keys = '0;
        edges(43);
        checks++;
        if (key_held !== 1'b1 || col !== 4'b1101) begin
            failures++;
            $display("FAIL release_pending got h=%b col=%b exp h=1 col=1101", key_held, col);
        end
        edges(1);
        checks++;
        if (key_held !== 1'b0 || col !== 4'b1011 || key_code !== 4'h9) begin
            failures++;
            $display("FAIL release_done got h=%b col=%b code=%h exp h=0 col=1011 code=9",
                     key_held, col, key_code);
        end
        checks++;
        if (vcount - start !== 1) begin
            failures++;
            $display("FAIL release_pulses got=%0d exp=1", vcount - start);
        end
    endtask

    task automatic test_rebounce();
        int start;
        do_reset();
        start = vcount;
        keys[9] = 1'b1;
        edges(100);
        keys = '0;
        edges(16);
        keys[9] = 1'b1;
        edges(34);
        checks++;
        if (key_held !== 1'b1 || col !== 4'b1101 || vcount - start !== 1) begin
            failures++;
            $display("FAIL rebounce_held got h=%b col=%b pulses=%0d exp h=1 col=1101 pulses=1",
                     key_held, col, vcount - start);
        end
        keys = '0;
        edges(50);
        checks++;
        if (key_held !== 1'b0 || col !== 4'b1011 || key_code !== 4'h9) begin
            failures++;
            $display("FAIL rebounce_release got h=%b col=%b code=%h exp h=0 col=1011 code=9",
                     key_held, col, key_code);
        end
    endtask

    task automatic test_multi_row();
        int start;
        do_reset();
        start = vcount;
        keys[2]  = 1'b1;  // row 0, column 2
        keys[14] = 1'b1;  // row 3, column 2
        edges(80);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h2 || key_held !== 1'b1 || col !== 4'b1011) begin
            failures++;
            $display("FAIL multi_accept got v=%b code=%h h=%b col=%b exp v=1 code=2 h=1 col=1011",
                     key_valid, key_code, key_held, col);
        end
        edges(20);
        checks++;
        if (vcount - start !== 1) begin
            failures++;
            $display("FAIL multi_pulses got=%0d exp=1", vcount - start);
        end
    endtask

    task automatic test_reset_held();
        do_reset();
        keys[9] = 1'b1;
        edges(90);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            failures++;
            $display("FAIL reset_held got col=%b v=%b h=%b code=%h exp col=1110 v=0 h=0 code=0",
                     col, key_valid, key_held, key_code);
        end
        keys = '0;
        @(negedge clk);
        reset = 1'b0;
        edges(8);
        checks++;
        if (col !== 4'b1110 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart got col=%b h=%b exp col=1110 h=0", col, key_held);
        end
    endtask

    task automatic test_long_hold();
        int start;
        do_reset();
        start = vcount;
        keys[9] = 1'b1;
        edges(390);  // 20 held ticks after acceptance
        keys = '0;
        edges(10);
        checks++;
        if (vcount - start !== EXP_HOLD_PULSES) begin
            failures++;
            $display("FAIL long_hold_pulses got=%0d exp=%0d", vcount - start, EXP_HOLD_PULSES);
        end
        checks++;
        if (last_code !== 4'h9 || key_held !== 1'b1) begin
            failures++;
            $display("FAIL long_hold_code got code=%h h=%b exp code=9 h=1", last_code, key_held);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        keys     = '0;
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_rebounce();
        test_multi_row();
        test_reset_held();
        test_long_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
